// File: rtl/commit_trace_buffer_if.sv
// Commit-record ingress and trace-record egress bundle for commit_trace_buffer.
// master = CPU commit source plus trace sink; slave = the trace buffer.
interface commit_trace_buffer_if;
    logic        commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_halt;
    logic        commit_reg_we;
    logic [4:0]  commit_reg_wa;
    logic [31:0] commit_reg_wd;
    logic        commit_dmem_we;
    logic [31:0] commit_dmem_wa;
    logic [31:0] commit_dmem_wd;

    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_inst;
    logic        trc_reg_we;
    logic [4:0]  trc_reg_wa;
    logic [31:0] trc_reg_wd;
    logic        trc_dmem_we;
    logic [31:0] trc_dmem_wa;
    logic [31:0] trc_dmem_wd;
    logic        trc_halt;

    modport master (
        output commit, commit_pc, commit_inst, commit_halt,
        output commit_reg_we, commit_reg_wa, commit_reg_wd,
        output commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
        output trc_ready,
        input  trc_valid, trc_pc, trc_inst, trc_reg_we, trc_reg_wa, trc_reg_wd,
        input  trc_dmem_we, trc_dmem_wa, trc_dmem_wd, trc_halt
    );

    modport slave (
        input  commit, commit_pc, commit_inst, commit_halt,
        input  commit_reg_we, commit_reg_wa, commit_reg_wd,
        input  commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
        input  trc_ready,
        output trc_valid, trc_pc, trc_inst, trc_reg_we, trc_reg_wa, trc_reg_wd,
        output trc_dmem_we, trc_dmem_wa, trc_dmem_wd, trc_halt
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Buffers retired-instruction records in a FIFO drained over valid/ready, with retire/cycle counters and halt tracking.
// Optional macro COMMIT_TRACE_FILTER_EN: skip records with no register or memory side effect.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 global_en,
    commit_trace_buffer_if.slave bus,
    output logic                 cpu_hold,
    output logic [31:0]          inst_cnt,
    output logic [31:0]          cycle_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 overflow,
    output logic                 done
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
        logic        halt;
    } rec_t;

    localparam int             HOLD_LVL_I = DEPTH - 2;
    localparam logic [PTR_W:0] HOLD_LVL   = HOLD_LVL_I[PTR_W:0];
    localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state;
    state_t         state_next;
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] occ;
    logic [PTR_W:0] occ_next;
    rec_t           mem [DEPTH];
    rec_t           in_rec;
    rec_t           head;
    rec_t           trc;
    logic           empty;
    logic           full;
    logic           trc_valid_i;
    logic           accept;
    logic           eligible;
    logic           push;
    logic           pop;
    logic           drop;

    assign in_rec = {bus.commit_pc, bus.commit_inst, bus.commit_reg_we, bus.commit_reg_wa,
                     bus.commit_reg_wd, bus.commit_dmem_we, bus.commit_dmem_wa,
                     bus.commit_dmem_wd, bus.commit_halt};

`ifdef COMMIT_TRACE_FILTER_EN
    // Keep only records that change architectural state; writes to x0 carry nothing.
    assign eligible = bus.commit_halt || bus.commit_dmem_we ||
                      (bus.commit_reg_we && (bus.commit_reg_wa != 5'd0));
`else
    assign eligible = 1'b1;
`endif

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign occ         = wr_ptr - rd_ptr;
    assign trc_valid_i = !empty && (state != DONE);
    assign pop         = trc_valid_i && bus.trc_ready;
    assign accept      = (state == RUN) && bus.commit;
    // A pop on the same edge frees the slot, so a full FIFO can still take a record.
    assign push        = accept && eligible && (!full || pop);
    assign drop        = accept && eligible && full && !pop;
    assign occ_next    = occ + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.commit && bus.commit_halt) state_next = HALT;
            HALT:    if (empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inst_cnt  <= '0;
            cycle_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            cpu_hold  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (accept) inst_cnt <= sat_inc32(inst_cnt);
            if ((state == RUN) && global_en) cycle_cnt <= sat_inc32(cycle_cnt);
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
            // Two-slot margin covers commits already in flight when the CPU sees hold.
            cpu_hold <= (state_next == RUN) && (occ_next >= HOLD_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= in_rec;
    end

    assign head = mem[rd_ptr[PTR_W-1:0]];
    assign trc  = trc_valid_i ? head : '0;
    assign done = (state == DONE);

    assign bus.trc_valid   = trc_valid_i;
    assign bus.trc_pc      = trc.pc;
    assign bus.trc_inst    = trc.inst;
    assign bus.trc_reg_we  = trc.reg_we;
    assign bus.trc_reg_wa  = trc.reg_wa;
    assign bus.trc_reg_wd  = trc.reg_wd;
    assign bus.trc_dmem_we = trc.dmem_we;
    assign bus.trc_dmem_wa = trc.dmem_wa;
    assign bus.trc_dmem_wd = trc.dmem_wd;
    assign bus.trc_halt    = trc.halt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
        logic        halt;
    } rec_t;

    logic        clk = 1'b0;
    logic        drv_rst;
    logic        drv_en;
    logic        drv_commit;
    logic        drv_ready;
    rec_t        cur;
    rec_t        act;
    logic        cpu_hold;
    logic        overflow;
    logic        done;
    logic [31:0] inst_cnt;
    logic [31:0] cycle_cnt;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    rec_t        mq[$];
    logic [31:0] m_inst;
    logic [31:0] m_cyc;
    logic [15:0] m_drop;
    logic        m_ovf;
    logic        m_hold;
    int          m_phase;   // 0 running, 1 halted/draining, 2 finished

    always #5 clk = ~clk;

    commit_trace_buffer_if bus ();

    assign bus.commit         = drv_commit;
    assign bus.commit_pc      = cur.pc;
    assign bus.commit_inst    = cur.inst;
    assign bus.commit_halt    = cur.halt;
    assign bus.commit_reg_we  = cur.reg_we;
    assign bus.commit_reg_wa  = cur.reg_wa;
    assign bus.commit_reg_wd  = cur.reg_wd;
    assign bus.commit_dmem_we = cur.dmem_we;
    assign bus.commit_dmem_wa = cur.dmem_wa;
    assign bus.commit_dmem_wd = cur.dmem_wd;
    assign bus.trc_ready      = drv_ready;

    assign act = {bus.trc_pc, bus.trc_inst, bus.trc_reg_we, bus.trc_reg_wa, bus.trc_reg_wd,
                  bus.trc_dmem_we, bus.trc_dmem_wa, bus.trc_dmem_wd, bus.trc_halt};

    commit_trace_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk       (clk),
        .rst       (drv_rst),
        .global_en (drv_en),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .inst_cnt  (inst_cnt),
        .cycle_cnt (cycle_cnt),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .done      (done)
    );

    function automatic bit rec_kept(rec_t r);
`ifdef COMMIT_TRACE_FILTER_EN
        return r.halt || r.dmem_we || (r.reg_we && (r.reg_wa != 5'd0));
`else
        return 1'b1;
`endif
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc      = $urandom;
        r.inst    = $urandom;
        r.reg_we  = 1'b1;
        r.reg_wa  = 5'($urandom_range(1, 31));
        r.reg_wd  = $urandom;
        r.dmem_we = 1'($urandom_range(0, 1));
        r.dmem_wa = $urandom;
        r.dmem_wd = $urandom;
        r.halt    = 1'b0;
        return r;
    endfunction

    // Applies the behavioural rules to the inputs present at this clock edge.
    task automatic model_edge();
        int sz;
        bit popping;
        if (!drv_rst) begin
            mq.delete();
            m_inst = '0; m_cyc = '0; m_drop = '0; m_ovf = 1'b0; m_hold = 1'b0; m_phase = 0;
            return;
        end
        sz = mq.size();
        popping = (m_phase != 2) && (sz > 0) && drv_ready;
        if (m_phase == 0 && drv_en && m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (popping) void'(mq.pop_front());
        if (m_phase == 0 && drv_commit) begin
            if (m_inst != 32'hFFFF_FFFF) m_inst++;
            if (rec_kept(cur)) begin
                if (sz < DEPTH || popping) mq.push_back(cur);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
            if (cur.halt) m_phase = 1;
        end else if (m_phase == 1 && sz == 0) begin
            m_phase = 2;
        end
        m_hold = (m_phase == 0) && (mq.size() >= DEPTH - 2);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drv_rst = 1'b0; drv_commit = 1'b0; drv_ready = 1'b0;
        cycle();
        drv_rst = 1'b1;
    endtask

    task automatic test_reset();
        drv_rst = 1'b0; drv_en = 1'b1; drv_commit = 1'b0; drv_ready = 1'b0; cur = '0;
        cycle();
        cycle();
        checks++; if (bus.trc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.trc_valid); end
        checks++; if (act !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", act); end
        checks++; if ({cpu_hold, overflow, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cpu_hold, overflow, done}); end
        checks++; if ({inst_cnt, cycle_cnt, drop_cnt} !== 80'd0) begin errors++; $display("FAIL reset_counts: got %h want 0", {inst_cnt, cycle_cnt, drop_cnt}); end
        drv_rst = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL idle_cycle_cnt: got %0d want 5", cycle_cnt); end
        checks++; if (inst_cnt !== 32'd0 || bus.trc_valid !== 1'b0) begin errors++; $display("FAIL idle_quiet: inst=%0d valid=%b want 0/0", inst_cnt, bus.trc_valid); end
    endtask

    task automatic test_single();
        rec_t r;
        do_reset();
        drv_ready = 1'b1;
        r = '{32'h1C00_0000, 32'h0010_0093, 1'b1, 5'd1, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0};
        cur = r; drv_commit = 1'b1;
        checks++; if (bus.trc_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", bus.trc_valid); end
        cycle();
        drv_commit = 1'b0;
        checks++; if (bus.trc_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.trc_valid); end
        checks++; if (act !== r) begin errors++; $display("FAIL single_fields: got %h want %h", act, r); end
        checks++; if (inst_cnt !== 32'd1) begin errors++; $display("FAIL single_inst_cnt: got %0d want 1", inst_cnt); end
        cycle();
        checks++; if (bus.trc_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", bus.trc_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs [DEPTH];
        do_reset();
        drv_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cur = rand_rec(); pcs[i] = cur.pc; drv_commit = 1'b1;
            cycle();
            checks++; if (cpu_hold !== (i >= DEPTH - 3)) begin errors++; $display("FAIL bp_hold_%0d: got %b want %b", i, cpu_hold, (i >= DEPTH - 3)); end
        end
        cur = rand_rec();
        cycle();
        drv_commit = 1'b0;
        checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop: ovf=%b drop=%0d want 1/1", overflow, drop_cnt); end
        checks++; if (inst_cnt !== 32'd17) begin errors++; $display("FAIL bp_inst_cnt: got %0d want 17", inst_cnt); end
        drv_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.trc_valid !== 1'b1 || bus.trc_pc !== pcs[i]) begin errors++; $display("FAIL bp_order_%0d: valid=%b pc=%h want 1/%h", i, bus.trc_valid, bus.trc_pc, pcs[i]); end
            cycle();
        end
        checks++; if (bus.trc_valid !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL bp_empty: valid=%b hold=%b want 0/0", bus.trc_valid, cpu_hold); end
    endtask

    task automatic test_full_pop();
        logic [31:0] pcs [DEPTH];
        logic [31:0] new_pc;
        int n;
        do_reset();
        drv_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cur = rand_rec(); pcs[i] = cur.pc; drv_commit = 1'b1;
            cycle();
        end
        cur = rand_rec(); new_pc = cur.pc; drv_ready = 1'b1;
        cycle();
        drv_commit = 1'b0;
        checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fp_no_drop: drop=%0d ovf=%b want 0/0", drop_cnt, overflow); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL fp_hold: got %b want 1", cpu_hold); end
        n = 0;
        while (bus.trc_valid === 1'b1 && n < DEPTH + 4) begin
            if (n < DEPTH - 1) begin
                checks++; if (bus.trc_pc !== pcs[n + 1]) begin errors++; $display("FAIL fp_order_%0d: got %h want %h", n, bus.trc_pc, pcs[n + 1]); end
            end else if (n == DEPTH - 1) begin
                checks++; if (bus.trc_pc !== new_pc) begin errors++; $display("FAIL fp_last: got %h want %h", bus.trc_pc, new_pc); end
            end
            n++;
            cycle();
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL fp_occupancy: got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_halt();
        do_reset();
        drv_ready = 1'b0; drv_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur = rand_rec(); drv_commit = 1'b1;
            cycle();
        end
        cur = rand_rec(); cur.inst = 32'h8000_0000; cur.halt = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cur = rand_rec();
            cycle();
        end
        drv_commit = 1'b0;
        checks++; if (inst_cnt !== 32'd4) begin errors++; $display("FAIL halt_inst_cnt: got %0d want 4", inst_cnt); end
        checks++; if (cycle_cnt !== m_cyc) begin errors++; $display("FAIL halt_cycle_frozen: got %0d want %0d", cycle_cnt, m_cyc); end
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL halt_pending: done=%b hold=%b want 0/0", done, cpu_hold); end
        drv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.trc_valid !== 1'b1 || bus.trc_halt !== (i == 3)) begin errors++; $display("FAIL halt_drain_%0d: valid=%b halt=%b want 1/%b", i, bus.trc_valid, bus.trc_halt, (i == 3)); end
            cycle();
        end
        checks++; if (bus.trc_valid !== 1'b0) begin errors++; $display("FAIL halt_empty: got %b want 0", bus.trc_valid); end
        cycle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b want 1", done); end
        cur = rand_rec(); drv_commit = 1'b1;
        cycle();
        cycle();
        drv_commit = 1'b0;
        checks++; if (done !== 1'b1 || bus.trc_valid !== 1'b0 || inst_cnt !== 32'd4) begin errors++; $display("FAIL done_sticky: done=%b valid=%b inst=%0d want 1/0/4", done, bus.trc_valid, inst_cnt); end
    endtask

    task automatic test_midrun_reset();
        rec_t r;
        do_reset();
        drv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur = rand_rec(); drv_commit = 1'b1;
            cycle();
        end
        drv_rst = 1'b0;
        cycle();
        drv_rst = 1'b1; drv_commit = 1'b0;
        checks++; if (bus.trc_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mr_state: valid=%b done=%b want 0/0", bus.trc_valid, done); end
        checks++; if ({inst_cnt, cycle_cnt, drop_cnt} !== 80'd0) begin errors++; $display("FAIL mr_counts: got %h want 0", {inst_cnt, cycle_cnt, drop_cnt}); end
        r = rand_rec(); cur = r; drv_commit = 1'b1;
        cycle();
        drv_commit = 1'b0;
        checks++; if (bus.trc_valid !== 1'b1 || act !== r || inst_cnt !== 32'd1) begin errors++; $display("FAIL mr_accept: valid=%b head=%h inst=%0d want 1/%h/1", bus.trc_valid, act, inst_cnt, r); end
    endtask

    task automatic test_random();
        rec_t exp_head;
        bit   exp_valid;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drv_rst    = ($urandom_range(0, 99) != 0);
            drv_en     = ($urandom_range(0, 9) < 8);
            drv_commit = (i < 250) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            drv_ready  = (i < 250) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            cur = rand_rec();
            cur.reg_we = 1'($urandom_range(0, 1));
            cycle();
            exp_valid = (m_phase != 2) && (mq.size() > 0);
            exp_head  = exp_valid ? mq[0] : '0;
            checks++; if (bus.trc_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.trc_valid, exp_valid); end
            checks++; if (act !== exp_head) begin errors++; $display("FAIL rnd_head@%0d: got %h want %h", i, act, exp_head); end
            checks++; if (inst_cnt !== m_inst) begin errors++; $display("FAIL rnd_inst@%0d: got %0d want %0d", i, inst_cnt, m_inst); end
            checks++; if (cycle_cnt !== m_cyc) begin errors++; $display("FAIL rnd_cycle@%0d: got %0d want %0d", i, cycle_cnt, m_cyc); end
            checks++; if (drop_cnt !== m_drop || overflow !== m_ovf) begin errors++; $display("FAIL rnd_drop@%0d: got %0d/%b want %0d/%b", i, drop_cnt, overflow, m_drop, m_ovf); end
            checks++; if (cpu_hold !== m_hold) begin errors++; $display("FAIL rnd_hold@%0d: got %b want %b", i, cpu_hold, m_hold); end
            checks++; if (done !== (m_phase == 2)) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", i, done, (m_phase == 2)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drv_rst = 1'b0; drv_en = 1'b0; drv_commit = 1'b0; drv_ready = 1'b0; cur = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_halt();
        test_midrun_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Consumes the pipelined CPU's registered commit interface (commit, commit_pc … commit_dmem_wd).
- Buffers each retired-instruction record in a FIFO and drains it through a valid/ready port to the debug/UART link.
- Tracks retire and cycle counters, and detects halt.
- Sits beside the CPU in the top level; its hold output gates global_en.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- PTR_W, 4, log2(DEPTH); pointers are PTR_W+1 bits, with the MSB used as the wrap bit.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk)
- global_en  in  1  CPU enable, sampled for the cycle counter
- commit  in  1  record valid this cycle
- commit_pc  in  32  retired PC
- commit_inst  in  32  retired instruction
- commit_halt  in  1  retired instruction is the halt instruction (32'h80000000)
- commit_reg_we  in  1  RF write enable
- commit_reg_wa  in  5  RF write address
- commit_reg_wd  in  32  RF write data
- commit_dmem_we  in  1  store flag
- commit_dmem_wa  in  32  store address
- commit_dmem_wd  in  32  store data
- trc_valid  out  1  head record available
- trc_ready  in  1  sink accepts head
- trc_pc  out  32  head PC
- trc_inst  out  32  head instruction
- trc_reg_we  out  1  head RF write enable
- trc_reg_wa  out  5  head RF write address
- trc_reg_wd  out  32  head RF write data
- trc_dmem_we  out  1  head store flag
- trc_dmem_wa  out  32  head store address
- trc_dmem_wd  out  32  head store data
- trc_halt  out  1  head is the halt record
- cpu_hold  out  1  request to deassert global_en
- inst_cnt  out  32  retired instructions
- cycle_cnt  out  32  enabled cycles while running
- drop_cnt  out  16  records lost to overflow
- overflow  out  1  sticky: at least one record dropped
- done  out  1  halt seen and FIFO drained

Behaviour:
- Reset (rst==0 at posedge): state=RUN, pointers=0, all counters=0, overflow=0, done=0.
  - trc_valid=0 and cpu_hold=0.
  - All trc_* data outputs read 0.
- Reset mid-operation discards FIFO contents with no drain; it takes priority over every other event that cycle.
- FIFO storage: synchronous-write register array. The head record is presented combinationally from the read pointer.
- Latency: a commit accepted at edge N gives trc_valid=1 after edge N if the FIFO was empty. There is no same-cycle bypass.
- Pop: trc_valid && trc_ready at posedge. Holds stay stable while trc_valid && !trc_ready.
- Push condition: state==RUN && commit && (!full || pop).
  - Push and pop in the same cycle when full: both happen, occupancy unchanged.
  - Push and pop in the same cycle when empty: push only, since trc_valid=0.
- Drop: state==RUN && commit && full && !pop.
  - Record is discarded.
  - overflow<=1.
  - drop_cnt increments, saturating at 16'hFFFF.
- full: pointer indices equal and wrap bits differ. empty: pointers equal.
- cpu_hold: registered; =1 when occupancy ≥ DEPTH-2 after the current edge, else 0. The two-entry margin absorbs the CPU's in-flight commit latency.
- inst_cnt: +1 for every commit pulse in RUN, whether pushed or dropped, including the halt. Saturates at 32'hFFFFFFFF.
- cycle_cnt: +1 each cycle with state==RUN && global_en. Saturates at 32'hFFFFFFFF.
- State machine:
  - RUN: on commit && commit_halt, the halt record is pushed (or dropped per the rules above) with trc_halt=1, then go to HALT.
  - HALT: commit inputs are ignored and no counters change except drop_cnt (which cannot change). When FIFO empty → DONE. If the halt record was dropped, the FIFO drains normally and DONE is still reached.
  - DONE: done=1. Sticky until reset; pop requests are ignored because trc_valid=0.
- cpu_hold is forced to 0 in HALT/DONE.

Optional Feature:
- Macro: COMMIT_TRACE_FILTER_EN.
- Defined: a commit record with commit_reg_we==0 && commit_dmem_we==0 && commit_halt==0 is not pushed and never drops. inst_cnt still counts it. Records with commit_reg_we==1 && commit_reg_wa==0 are also filtered unless commit_dmem_we==1.
- Undefined: every commit record is eligible for push; there is no filter logic.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 → all outputs 0; state RUN; cycle_cnt increments by 1 per cycle with global_en=1.
- Single record, trc_ready=1: commit PC 0x1C000000, inst 0x00100093, reg_we=1, wa=1, wd=1 → trc_valid=1 exactly one cycle later with matching fields; inst_cnt=1; FIFO empty afterwards.
- Backpressure fill, trc_ready=0, DEPTH=16:
  - 16 consecutive commits → cpu_hold=1 after the 14th push.
  - 17th commit is dropped: overflow=1, drop_cnt=1, inst_cnt=17.
  - Raise trc_ready: records emerge in order, first PC first.
- Full with simultaneous pop: FIFO full, trc_ready=1, commit=1 on the same edge → occupancy stays 16; the new record appears as the 16th entry; drop_cnt unchanged.
- Halt flow: 3 commits, then commit_halt with inst 0x80000000, trc_ready=0, then further commit pulses → those later pulses are ignored and inst_cnt=4. Drain with trc_ready=1: 4th record has trc_halt=1; done=1 on the cycle after the last pop.
- Mid-run reset: 5 records buffered, rst=0 for one edge → trc_valid=0, counters 0, done=0; a subsequent commit is accepted normally.
